// File: rtl/rtc_tick_gen.sv
// rtc_tick_gen -- fractional-N RTC square-wave generator (clk_i domain).
//
// Each enabled cycle a phase accumulator adds inc_q. Every carry-out flips
// rtc_o, so f_rtc = f_clk * inc_q / 2^(ACC_WIDTH+1). This allows non-integer
// clk/rtc ratios while keeping the long-term rate exact.
//
// Ports
//   clk_i        clock
//   rst_ni       async reset, active low (release is expected synchronous to clk_i)
//   testmode_i   rtc_o toggles on every enabled cycle; phase holds
//   en_i         advance; when low all state holds and tick_o drops
//   clear_i      synchronous clear of phase, rtc_o and tick_o (inc_q kept)
//   inc_i        new phase increment
//   inc_valid_i  one-cycle strobe that loads inc_i
//   rtc_o        registered square wave, to CLINT rtc_i
//   tick_o       one-cycle pulse in the first cycle rtc_o is high
//   inc_o        active increment readback
module rtc_tick_gen #(
  parameter int unsigned          ACC_WIDTH   = 32,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = 32'd2814750
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 testmode_i,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic [ACC_WIDTH-1:0] inc_i,
  input  logic                 inc_valid_i,
  output logic                 rtc_o,
  output logic                 tick_o,
  output logic [ACC_WIDTH-1:0] inc_o
);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] inc_q;
  logic [ACC_WIDTH:0]   sum;
  logic                 rtc_q;
  logic                 tick_q;

  // One extra bit holds the carry; the low bits wrap into acc_q.
  assign sum = {1'b0, acc_q} + {1'b0, inc_q};

  // Increment register is independent of clear/enable/testmode so software
  // can retune at any time; acc_q is never touched here, keeping phase
  // continuous across a load. The new value is first used on the next add.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          inc_q <= DEFAULT_INC;
    else if (inc_valid_i) inc_q <= inc_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      rtc_q  <= 1'b0;
      tick_q <= 1'b0;
    end else if (clear_i) begin
      acc_q  <= '0;
      rtc_q  <= 1'b0;
      tick_q <= 1'b0;
    end else if (!en_i) begin
      tick_q <= 1'b0;
    end else if (testmode_i) begin
      rtc_q  <= ~rtc_q;
      tick_q <= ~rtc_q;
    end else begin
      acc_q <= sum[ACC_WIDTH-1:0];
      if (sum[ACC_WIDTH]) begin
        rtc_q  <= ~rtc_q;
        // Tick only on the 0->1 transition, i.e. once per rtc period.
        tick_q <= ~rtc_q;
      end else begin
        tick_q <= 1'b0;
      end
    end
  end

  // All outputs come straight from flops: glitch-free, no input->output path.
  assign rtc_o  = rtc_q;
  assign tick_o = tick_q;
  assign inc_o  = inc_q;

endmodule
